// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic STOP_VAL        = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: down-counter that pulses tick on terminal count.
module uart_os_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= CW'(DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit decisions and a small show-ahead FIFO.
//   state | meaning
//   IDLE  | waiting for a synchronized falling edge
//   START | validating the start bit, false starts return to IDLE
//   DATA  | shifting in 8 data bits, LSB first
//   STOP  | stop-bit decision: push byte or flag framing error
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       rx_serial,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  rx_state_t     state;
  logic          sync1, sync2, rx_prev;
  logic [SW-1:0] samp_cnt;
  logic [2:0]    bit_cnt;
  logic          smp_a, smp_b;
  logic [7:0]    shreg;
  logic          tick, fall, restart, decide, bit_val, push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_ok;

  // rx_prev gives edge detection on the already-synchronized line
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      {sync1, sync2, rx_prev} <= 3'b111;
    end else begin
      {sync1, sync2, rx_prev} <= {rx_serial, sync1, sync2};
    end
  end

  assign fall    = rx_prev & ~sync2;
  assign restart = (state == IDLE) & fall;
  assign decide  = tick && (samp_cnt == S_HI);
  assign bit_val = majority3(smp_a, smp_b, sync2);
  assign push    = (state == STOP) && decide && (bit_val == STOP_VAL);

  uart_os_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst_   (rst_),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      smp_a    <= 1'b0;
      smp_b    <= 1'b0;
      shreg    <= '0;
      rx_error <= 1'b0;
    end else begin
      rx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            samp_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        default: begin
          if (tick) begin
            samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + 1'b1;
            if (samp_cnt == S_LO)  smp_a <= sync2;
            if (samp_cnt == S_MID) smp_b <= sync2;
            case (state)
              START: begin
                if (decide && bit_val) state <= IDLE;
                else if (samp_cnt == S_END) state <= DATA;
              end
              DATA: begin
                if (decide) shreg <= {bit_val, shreg[7:1]};
                if (samp_cnt == S_END) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) state <= STOP;
                end
              end
              STOP: begin
                // leave mid-bit so a frame starting right after the stop bit is caught
                if (decide) begin
                  state    <= IDLE;
                  rx_error <= (bit_val != STOP_VAL);
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rd_en & ~empty;
  assign wr_ok = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      rx_overrun <= push & full & ~pop;
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rx_data  = mem[rd_ptr[AW-1:0]];
  assign rx_valid = ~empty;

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; an even value of at least 8.
REQ-004 Parameter FIFO_DEPTH, default 4, received-byte buffer entries; a power of 2.
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 rst_  input  1  asynchronous, active-low reset.
REQ-007 rx_serial  input  1  asynchronous serial line; idles high.
REQ-008 rd_en  input  1  pops the FIFO head when rx_valid=1.
REQ-009 rx_data  output  8  FIFO head byte, show-ahead.
REQ-010 rx_valid  output  1  FIFO not empty.
REQ-011 rx_error  output  1  one-cycle pulse on a framing error (stop bit = 0).
REQ-012 rx_overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-013 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 rx_serial SHALL pass through a 2-flop synchronizer before any use; the synchronizer reset value is 1.
REQ-015 The tick divisor SHALL be CLK_FREQ/(BAUD_RATE*OVERSAMPLE) with integer truncation (27 at defaults); one tick is a one-clock pulse.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE: a synchronized high-to-low transition SHALL enter START, restart the tick divider at 0 and clear the sample counter.
REQ-018 Each bit SHALL occupy OVERSAMPLE ticks; the bit decision is the majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-019 START: a majority of 1 SHALL return the FSM to IDLE (false start), with no error and no push; a majority of 0 SHALL proceed to DATA at the bit boundary.
REQ-020 DATA: the FSM SHALL shift in 8 bits LSB first, then enter STOP.
REQ-021 STOP: at the stop-bit decision, a 1 pushes the byte and a 0 pulses rx_error with the byte discarded; the FSM SHALL return to IDLE in the same cycle, without waiting for the bit end, so that back-to-back frames work.
REQ-022 rx_valid SHALL assert the clock after the push; total latency from the stop-bit mid-sample is 1 clock.
REQ-023 The FIFO SHALL be a circular buffer whose pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap-around via the MSB.
REQ-024 Full with push and no pop: the byte SHALL be dropped and rx_overrun pulsed, with FIFO contents unchanged.
REQ-025 Full with push and pop in the same cycle: both SHALL occur, with no overrun.
REQ-026 Empty with rd_en: the pop SHALL be ignored, with pointers unchanged.
REQ-027 A line that stays low after a framing error SHALL NOT start a new frame until a high-to-low edge is seen.

Reset
REQ-028 While rst_=0: FSM=IDLE, counters=0, FIFO pointers=0, rx_data=8'h00, rx_valid=0, rx_error=0, rx_overrun=0, rx_busy=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without a push or error; after release, the block waits for a fresh start edge.

Structure
REQ-030 Package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP) and the constants FRAME_DATA_BITS=8 and STOP_VAL=1'b1.
REQ-031 The tick generator SHALL be the sub-module uart_os_tick (ports: clk, rst_, restart, tick), parameterized by CLK_FREQ, BAUD_RATE and OVERSAMPLE.
REQ-032 The FIFO SHALL be inline in uart_rx_os; there is no separate memory macro.

Verification
REQ-033 Frame 0xA5 at 115200 with rd_en=0 -> rx_valid=1 with rx_data=8'hA5 one clock after the stop mid-sample; rx_error=0.
REQ-034 rx_serial low for 10 clocks, then high -> FSM back to IDLE after the start decision; rx_valid=0, rx_error=0.
REQ-035 Frame 0xFF with stop bit = 0 -> rx_error high for exactly 1 clock; rx_valid stays 0.
REQ-036 Frames 0x01..0x05 back-to-back, no reads -> 0x01..0x04 read out in order; rx_overrun pulses once on the 0x05 frame.
REQ-037 rst_ pulsed low during bit 3 of a frame, then frame 0x3C sent -> only 0x3C received; no error.
REQ-038 FIFO full, with rd_en held on the clock of a new push -> no overrun, count stays 4, head advances.
